fir_cmplx_decim: RTL
====================

# fir_cmplx_decim

Parametrised complex-coefficient FIR with integer decimation for the FM radio datapath. It reads paired I/Q samples from upstream show-ahead FIFOs and computes one complex output per DECIMATION input samples using a single time-shared complex MAC. It writes real/imag results to downstream FIFOs. It is the generalised successor to the fixed 20-tap real-coefficient channel filter, intended for the channel filter and later decimating stages.

## Interface
- DATA_WIDTH, 32: sample and coefficient width, two's complement.
- TAPS, 20: number of taps, ≥2.
- DECIMATION, 1: input samples consumed per output, ≥1.
- FRAC_BITS, 10: fixed-point fraction bits; per-product arithmetic right shift.
- H_REAL, all zero: packed [0:TAPS-1][DATA_WIDTH-1:0], real coefficients; H_REAL[k] weights x[n-k].
- H_IMAG, all zero: same layout, imaginary coefficients.
- clock in 1: sole clock.
- reset in 1: synchronous, active-high.
- i_in in DATA_WIDTH: I sample, head of the I FIFO.
- q_in in DATA_WIDTH: Q sample, head of the Q FIFO.
- i_empty, q_empty in 1: upstream FIFO empty flags.
- i_rd_en, q_rd_en out 1: pop strobes. Always equal.
- y_out_real, y_out_imag out DATA_WIDTH: result words.
- y_real_wr_en, y_imag_wr_en out 1: push strobes. Always equal.
- y_real_full, y_imag_full in 1: downstream FIFO full flags.

## Operation
- Upstream FIFOs are show-ahead: i_in/q_in are valid whenever the corresponding empty flag is low. rd_en pops the head at the clock edge.
- The block holds a TAPS-deep complex shift register x[0..TAPS-1], with x[0] the newest sample. A sample read shifts the register and loads {i_in,q_in} into x[0].
- FSM states:
  - S_LOAD: rd_en = !i_empty && !q_empty (combinational). Each pop shifts in one sample and increments a load counter. After the DECIMATION-th pop, clear the counter and the accumulators, and go to S_MAC.
  - S_MAC: tap counter k runs 0..TAPS-1, one tap per cycle. For each tap:
    - acc_re += (Hr[k]·xr[k]) >>> F − (Hi[k]·xi[k]) >>> F
    - acc_im += (Hr[k]·xi[k]) >>> F + (Hi[k]·xr[k]) >>> F
    - After k = TAPS-1, go to S_OUT.
  - S_OUT: if !y_real_full && !y_imag_full, assert both wr_en for one cycle with y_out = low DATA_WIDTH bits of the accumulators, then go to S_LOAD. Otherwise hold.
- Arithmetic rules:
  - Products are full 2·DATA_WIDTH signed.
  - The shift is arithmetic, so it floors toward −∞.
  - Accumulators are 2·DATA_WIDTH+clog2(TAPS)+1 bits. No saturation; output is truncation.
- Outputs are produced for n = DECIMATION·m + DECIMATION−1 (m = 0,1,…). Taps older than the first sample read as zero.
- y_out_real/imag are registered and hold their value between writes.

## Timing
- Reset values:
  - state = S_LOAD
  - shift register, accumulators and counters = 0
  - y_out_real = y_out_imag = 0
  - wr_en = 0
  - rd_en = 0 while reset is high
- Reset mid-operation discards the partial sample set and accumulation. No write occurs in or after the reset cycle.
- With no stalls, each output costs DECIMATION (S_LOAD) + TAPS (S_MAC) + 1 (S_OUT) cycles.
- Latency from the final contributing pop edge to the wr_en cycle is TAPS+1 cycles.
- Empty stall: S_LOAD waits with rd_en low. The load counter and shift register do not change.
- Full stall: S_OUT holds with wr_en low, y_out stable and no reads. The write occurs in the first cycle both full flags are low.
- i_empty and q_empty are combined: no pop occurs unless both FIFOs are non-empty. y_real_full and y_imag_full are combined the same way.
- The block never reads and writes in the same cycle.

## Test plan
- **I impulse**, TAPS=4, DEC=1, F=10, H_REAL={1024,2048,0,−1024}, H_IMAG={0,0,1024,0}.
  - Stimulus: I=1024, Q=0, then three zero samples.
  - Required: y_real = 1024, 2048, 0, −1024; y_imag = 0, 0, 1024, 0.
  - Required: exactly TAPS+1 cycles from each pop to its wr_en.
- **Q impulse**, same configuration.
  - Stimulus: I=0, Q=1024.
  - Required: y_real = 0, 0, −1024, 0; y_imag = 1024, 2048, 0, −1024.
- **Decimation**, DEC=2, same taps.
  - Stimulus: I impulse followed by 3 zeros.
  - Required: exactly two outputs, y_real = 2048, −1024 and y_imag = 0, 0.
  - Required: 2 pops precede each write.
- **Backpressure.**
  - Stimulus: y_real_full held high for 50 cycles while in S_OUT.
  - Required: wr_en = 0, rd_en = 0 and y_out stable throughout; one write on release; output sequence unchanged.
- **Bubbles and flooring.**
  - Stimulus: random empty gaps on either FIFO with 200 random samples, plus one case xr=−1, Hr[0]=1.
  - Required: outputs bit-exact to the fixed-point model; the flooring case yields y_real=−1.
- **Reset mid-MAC.**
  - Stimulus: reset for one cycle during S_MAC, then rerun the I impulse.
  - Required: no write from the aborted output; outputs match the I impulse scenario exactly.

Source files
------------

// File: rtl/fir_cmplx_decim.sv
// Complex-coefficient decimating FIR: loads DECIMATION I/Q samples from
// show-ahead FIFOs, runs one time-shared complex MAC over all taps, then
// pushes one complex result to the downstream FIFOs.
module fir_cmplx_decim #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TAPS       = 20,
    parameter int unsigned DECIMATION = 1,
    parameter int unsigned FRAC_BITS  = 10,
    parameter logic [0:TAPS-1][DATA_WIDTH-1:0] H_REAL = '0,
    parameter logic [0:TAPS-1][DATA_WIDTH-1:0] H_IMAG = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] i_in,
    input  logic [DATA_WIDTH-1:0] q_in,
    input  logic                  i_empty,
    input  logic                  q_empty,
    output logic                  i_rd_en,
    output logic                  q_rd_en,
    output logic [DATA_WIDTH-1:0] y_out_real,
    output logic [DATA_WIDTH-1:0] y_out_imag,
    output logic                  y_real_wr_en,
    output logic                  y_imag_wr_en,
    input  logic                  y_real_full,
    input  logic                  y_imag_full
);

    localparam int unsigned PW = 2 * DATA_WIDTH;
    localparam int unsigned AW = PW + $clog2(TAPS) + 1;
    localparam int unsigned KW = $clog2(TAPS);
    localparam int unsigned LW = $clog2(DECIMATION + 1);

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_MAC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t                       state_q;
    logic [LW-1:0]                load_cnt_q;
    logic [KW-1:0]                tap_q;
    logic signed [AW-1:0]         acc_re_q;
    logic signed [AW-1:0]         acc_im_q;
    logic signed [AW-1:0]         acc_re_d;
    logic signed [AW-1:0]         acc_im_d;
    logic signed [DATA_WIDTH-1:0] xr_q [TAPS];
    logic signed [DATA_WIDTH-1:0] xi_q [TAPS];
    logic [DATA_WIDTH-1:0]        y_re_q;
    logic [DATA_WIDTH-1:0]        y_im_q;

    logic                         pop_c;
    logic                         push_c;

    logic signed [DATA_WIDTH-1:0] hr_s;
    logic signed [DATA_WIDTH-1:0] hi_s;
    logic signed [DATA_WIDTH-1:0] xr_s;
    logic signed [DATA_WIDTH-1:0] xi_s;
    logic signed [PW-1:0]         p_rr;
    logic signed [PW-1:0]         p_ii;
    logic signed [PW-1:0]         p_ri;
    logic signed [PW-1:0]         p_ir;
    logic signed [AW-1:0]         sh_rr;
    logic signed [AW-1:0]         sh_ii;
    logic signed [AW-1:0]         sh_ri;
    logic signed [AW-1:0]         sh_ir;

    // Pop/push strobes: both FIFO pairs are treated as one; nothing moves during reset.
    assign pop_c  = (state_q == S_LOAD) && !i_empty && !q_empty && !reset;
    assign push_c = (state_q == S_OUT) && !y_real_full && !y_imag_full && !reset;

    assign i_rd_en      = pop_c;
    assign q_rd_en      = pop_c;
    assign y_real_wr_en = push_c;
    assign y_imag_wr_en = push_c;
    assign y_out_real   = y_re_q;
    assign y_out_imag   = y_im_q;

    // One complex tap: four full-width products, each floored by the fraction shift.
    always_comb begin
        hr_s     = signed'(H_REAL[tap_q]);
        hi_s     = signed'(H_IMAG[tap_q]);
        xr_s     = xr_q[tap_q];
        xi_s     = xi_q[tap_q];
        p_rr     = PW'(hr_s) * PW'(xr_s);
        p_ii     = PW'(hi_s) * PW'(xi_s);
        p_ri     = PW'(hr_s) * PW'(xi_s);
        p_ir     = PW'(hi_s) * PW'(xr_s);
        sh_rr    = AW'(p_rr >>> FRAC_BITS);
        sh_ii    = AW'(p_ii >>> FRAC_BITS);
        sh_ri    = AW'(p_ri >>> FRAC_BITS);
        sh_ir    = AW'(p_ir >>> FRAC_BITS);
        acc_re_d = acc_re_q + sh_rr - sh_ii;
        acc_im_d = acc_im_q + sh_ri + sh_ir;
    end

    // Control FSM and datapath registers; the result is latched on the last tap
    // so it is already stable while S_OUT waits for downstream space.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_LOAD;
            load_cnt_q <= '0;
            tap_q      <= '0;
            acc_re_q   <= '0;
            acc_im_q   <= '0;
            y_re_q     <= '0;
            y_im_q     <= '0;
            for (int k = 0; k < int'(TAPS); k++) begin
                xr_q[k] <= '0;
                xi_q[k] <= '0;
            end
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (pop_c) begin
                        for (int k = int'(TAPS) - 1; k > 0; k--) begin
                            xr_q[k] <= xr_q[k-1];
                            xi_q[k] <= xi_q[k-1];
                        end
                        xr_q[0] <= signed'(i_in);
                        xi_q[0] <= signed'(q_in);
                        if (load_cnt_q == LW'(DECIMATION - 1)) begin
                            load_cnt_q <= '0;
                            acc_re_q   <= '0;
                            acc_im_q   <= '0;
                            tap_q      <= '0;
                            state_q    <= S_MAC;
                        end else begin
                            load_cnt_q <= load_cnt_q + LW'(1);
                        end
                    end
                end
                S_MAC: begin
                    acc_re_q <= acc_re_d;
                    acc_im_q <= acc_im_d;
                    if (tap_q == KW'(TAPS - 1)) begin
                        tap_q   <= '0;
                        y_re_q  <= acc_re_d[DATA_WIDTH-1:0];
                        y_im_q  <= acc_im_d[DATA_WIDTH-1:0];
                        state_q <= S_OUT;
                    end else begin
                        tap_q <= tap_q + KW'(1);
                    end
                end
                S_OUT: begin
                    if (push_c) begin
                        state_q <= S_LOAD;
                    end
                end
                default: state_q <= S_LOAD;
            endcase
        end
    end

endmodule
